// File: rtl/pipe_defs_pkg.sv
// Shared pipeline definitions.
//   pipe_ctrl_state_e : state of the pipeline controller
//                       RUN   - normal issue
//                       DRAIN - a serialising instruction (CSR write / MRET)
//                               waits in DE until EX/MEM/WB are empty
package pipe_defs_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_reg_pkg.sv
// Shared pipeline-register definitions.
//   stage_ctrl_t : per-stage register control
//                  stall  - the stage output register holds its contents
//                  squash - the stage output register loads valid=0
package pipe_reg_pkg;

    typedef struct packed {
        logic stall;
        logic squash;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rf_wr_en_i, ex_rd_i : load in EX writing ex_rd_i
//   de_valid_i, de_rs{1,2}_used_i, de_rs{1,2}_i       : sources read by DE
//   load_use_o                                        : DE needs a value EX has not loaded yet
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_rf_wr_en_i,
    input  logic [4:0] ex_rd_i,
    input  logic       de_valid_i,
    input  logic       de_rs1_used_i,
    input  logic       de_rs2_used_i,
    input  logic [4:0] de_rs1_i,
    input  logic [4:0] de_rs2_i,
    output logic       load_use_o
);

    logic ex_load_wr;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign ex_load_wr = ex_valid_i & ex_mem_read_i & ex_rf_wr_en_i & (ex_rd_i != 5'd0);
    assign rs1_hit    = de_rs1_used_i & (de_rs1_i == ex_rd_i);
    assign rs2_hit    = de_rs2_used_i & (de_rs2_i == ex_rd_i);
    assign load_use_o = ex_load_wr & de_valid_i & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/squash controller.
// Ports:
//   clk_i, rst_ni                       : clock, async active-low reset
//   de_*                                : decode-stage instruction info
//   ex_valid_i, mem_valid_i, wb_valid_i : stage register validity
//   ex_mem_read_i, ex_rf_wr_en_i, ex_rd_i : execute-stage load/destination info
//   ex_redirect_i                       : taken branch / jump / MRET resolved in EX
//   dmem_busy_i                         : data memory access not yet complete
//   {if,de,ex,mem,wb}_ctrl_o            : stall/squash per stage output register
//   stall_cnt_o                         : saturating count of IF-stall cycles
//   state_o                             : controller state (debug visibility)
// Controls are combinational from state and inputs (zero latency).
// Priority, highest first: dmem_busy, redirect, DRAIN, load-use, run.
module pipeline_ctrl
    import pipe_defs_pkg::*;
    import pipe_reg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             de_valid_i,
    input  logic             de_rs1_used_i,
    input  logic             de_rs2_used_i,
    input  logic [4:0]       de_rs1_i,
    input  logic [4:0]       de_rs2_i,
    input  logic             de_serial_i,
    input  logic             ex_valid_i,
    input  logic             mem_valid_i,
    input  logic             wb_valid_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_rf_wr_en_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_redirect_i,
    input  logic             dmem_busy_i,
    output stage_ctrl_t      if_ctrl_o,
    output stage_ctrl_t      de_ctrl_o,
    output stage_ctrl_t      ex_ctrl_o,
    output stage_ctrl_t      mem_ctrl_o,
    output stage_ctrl_t      wb_ctrl_o,
    output logic [31:0]      stall_cnt_o,
    output pipe_ctrl_state_e state_o
);

    pipe_ctrl_state_e state_q;
    pipe_ctrl_state_e state_d;
    logic [31:0]      stall_cnt_q;
    logic             load_use;
    logic             pipe_busy;

    hazard_detect u_hazard_detect (
        .ex_valid_i    (ex_valid_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rf_wr_en_i (ex_rf_wr_en_i),
        .ex_rd_i       (ex_rd_i),
        .de_valid_i    (de_valid_i),
        .de_rs1_used_i (de_rs1_used_i),
        .de_rs2_used_i (de_rs2_used_i),
        .de_rs1_i      (de_rs1_i),
        .de_rs2_i      (de_rs2_i),
        .load_use_o    (load_use)
    );

    // Anything still in flight behind DE that a serial instruction must wait for.
    assign pipe_busy = ex_valid_i | mem_valid_i | wb_valid_i;

    always_comb begin
        if_ctrl_o  = '0;
        de_ctrl_o  = '0;
        ex_ctrl_o  = '0;
        mem_ctrl_o = '0;
        wb_ctrl_o  = '0;
        state_d    = state_q;

        if (!rst_ni) begin
            // Flush every downstream register while reset is held.
            de_ctrl_o.squash  = 1'b1;
            ex_ctrl_o.squash  = 1'b1;
            mem_ctrl_o.squash = 1'b1;
            wb_ctrl_o.squash  = 1'b1;
            state_d           = RUN;
        end else if (dmem_busy_i) begin
            // Freeze everything up to MEM; WB must not retire the pending access twice.
            if_ctrl_o.stall  = 1'b1;
            de_ctrl_o.stall  = 1'b1;
            ex_ctrl_o.stall  = 1'b1;
            mem_ctrl_o.stall = 1'b1;
            wb_ctrl_o.squash = 1'b1;
        end else if (ex_redirect_i) begin
            // Wrong-path instructions in DE and EX are discarded; a pending drain
            // is abandoned because the serial instruction itself was wrong-path.
            de_ctrl_o.squash = 1'b1;
            ex_ctrl_o.squash = 1'b1;
            state_d          = RUN;
        end else if (state_q == DRAIN) begin
            if (pipe_busy) begin
                if_ctrl_o.stall  = 1'b1;
                de_ctrl_o.stall  = 1'b1;
                ex_ctrl_o.squash = 1'b1;
            end else begin
                // Pipeline empty: let the serial instruction advance this cycle.
                state_d = RUN;
            end
        end else if (de_valid_i && de_serial_i && pipe_busy) begin
            if_ctrl_o.stall  = 1'b1;
            de_ctrl_o.stall  = 1'b1;
            ex_ctrl_o.squash = 1'b1;
            state_d          = DRAIN;
        end else if (load_use) begin
            // One bubble; the load result is forwardable on the following cycle.
            if_ctrl_o.stall  = 1'b1;
            de_ctrl_o.stall  = 1'b1;
            ex_ctrl_o.squash = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (if_ctrl_o.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios followed by randomized cycles,
// all compared against a rule-level reference model.
module tb_pipeline_ctrl;
    import pipe_defs_pkg::*;
    import pipe_reg_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             de_valid_i, de_rs1_used_i, de_rs2_used_i, de_serial_i;
    logic [4:0]       de_rs1_i, de_rs2_i, ex_rd_i;
    logic             ex_valid_i, mem_valid_i, wb_valid_i;
    logic             ex_mem_read_i, ex_rf_wr_en_i, ex_redirect_i, dmem_busy_i;
    stage_ctrl_t      if_ctrl_o, de_ctrl_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o;
    logic [31:0]      stall_cnt_o;
    pipe_ctrl_state_e state_o;

    int          checks = 0;
    int          errors = 0;
    bit          m_drain = 1'b0;
    logic [31:0] m_cnt = '0;

    pipeline_ctrl dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .de_valid_i    (de_valid_i),
        .de_rs1_used_i (de_rs1_used_i),
        .de_rs2_used_i (de_rs2_used_i),
        .de_rs1_i      (de_rs1_i),
        .de_rs2_i      (de_rs2_i),
        .de_serial_i   (de_serial_i),
        .ex_valid_i    (ex_valid_i),
        .mem_valid_i   (mem_valid_i),
        .wb_valid_i    (wb_valid_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rf_wr_en_i (ex_rf_wr_en_i),
        .ex_rd_i       (ex_rd_i),
        .ex_redirect_i (ex_redirect_i),
        .dmem_busy_i   (dmem_busy_i),
        .if_ctrl_o     (if_ctrl_o),
        .de_ctrl_o     (de_ctrl_o),
        .ex_ctrl_o     (ex_ctrl_o),
        .mem_ctrl_o    (mem_ctrl_o),
        .wb_ctrl_o     (wb_ctrl_o),
        .stall_cnt_o   (stall_cnt_o),
        .state_o       (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    // Expected controls packed as {if, de, ex, mem, wb}, each {stall, squash}.
    function automatic logic [9:0] exp_ctrl();
        logic [4:0] srcs [2];
        logic       used [2];
        bit         in_flight;
        bit         hazard;
        srcs[0] = de_rs1_i; srcs[1] = de_rs2_i;
        used[0] = de_rs1_used_i; used[1] = de_rs2_used_i;
        in_flight = ex_valid_i || mem_valid_i || wb_valid_i;
        hazard = 1'b0;
        if (ex_valid_i && ex_mem_read_i && ex_rf_wr_en_i && ex_rd_i != 0 && de_valid_i)
            for (int k = 0; k < 2; k++)
                if (used[k] && srcs[k] == ex_rd_i) hazard = 1'b1;
        if (!rst_ni)        return 10'b00_01_01_01_01;
        if (dmem_busy_i)    return 10'b10_10_10_10_01;
        if (ex_redirect_i)  return 10'b00_01_01_00_00;
        if (m_drain)        return in_flight ? 10'b10_10_01_00_00 : 10'b0;
        if ((de_valid_i && de_serial_i && in_flight) || hazard) return 10'b10_10_01_00_00;
        return 10'b0;
    endfunction

    function automatic bit exp_next_drain();
        bit in_flight;
        in_flight = ex_valid_i || mem_valid_i || wb_valid_i;
        if (!rst_ni)       return 1'b0;
        if (dmem_busy_i)   return m_drain;
        if (ex_redirect_i) return 1'b0;
        if (m_drain)       return in_flight;
        return de_valid_i && de_serial_i && in_flight;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        de_valid_i = 0; de_rs1_used_i = 0; de_rs2_used_i = 0; de_serial_i = 0;
        de_rs1_i = 0; de_rs2_i = 0; ex_rd_i = 0;
        ex_valid_i = 0; mem_valid_i = 0; wb_valid_i = 0;
        ex_mem_read_i = 0; ex_rf_wr_en_i = 0; ex_redirect_i = 0; dmem_busy_i = 0;
    endtask

    task automatic check_now(input string tag);
        logic [9:0]  obs;
        logic [9:0]  exp;
        logic [31:0] exp_cnt;
        obs = {if_ctrl_o, de_ctrl_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o};
        exp = exp_ctrl();
        exp_cnt = rst_ni ? m_cnt : 32'd0;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, obs, exp);
        end
        checks++;
        assert (stall_cnt_o === exp_cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt: observed %h expected %h", tag, stall_cnt_o, exp_cnt);
        end
        checks++;
        assert ((state_o === DRAIN) === (rst_ni ? m_drain : 1'b0)) else begin
            errors++;
            $error("FAIL %s state: observed drain=%b expected drain=%b", tag,
                   state_o === DRAIN, rst_ni ? m_drain : 1'b0);
        end
    endtask

    // Called just after a rising edge with inputs already set: checks, then
    // advances the model across the next rising edge.
    task automatic step(input string tag);
        logic [9:0] e;
        bit         nd;
        #1;
        check_now(tag);
        e  = exp_ctrl();
        nd = exp_next_drain();
        @(posedge clk_i);
        if (!rst_ni) begin
            m_drain = 1'b0;
            m_cnt   = '0;
        end else begin
            m_drain = nd;
            if (e[9] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        step("reset");
        rst_ni = 1'b1;
    endtask

    task automatic set_load_ex(input logic [4:0] rd);
        ex_valid_i = 1; ex_mem_read_i = 1; ex_rf_wr_en_i = 1; ex_rd_i = rd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle();
        #1;
        check_now("reset_initial");
        @(posedge clk_i); #1;
        do_reset();

        // Load-use on rs1, then clear; then the same load to x0.
        set_load_ex(5'd5); de_valid_i = 1; de_rs1_used_i = 1; de_rs1_i = 5'd5;
        step("load_use_rs1");
        idle(); step("after_load_use");
        set_load_ex(5'd0); de_valid_i = 1; de_rs1_used_i = 1; de_rs1_i = 5'd0;
        step("load_x0");
        set_load_ex(5'd9); de_valid_i = 1; de_rs2_used_i = 1; de_rs2_i = 5'd9;
        step("load_use_rs2");
        set_load_ex(5'd9); de_valid_i = 1; de_rs2_used_i = 0; de_rs2_i = 5'd9;
        step("unused_rs2");

        // Redirect together with load-use.
        set_load_ex(5'd5); de_valid_i = 1; de_rs1_used_i = 1; de_rs1_i = 5'd5;
        ex_redirect_i = 1;
        step("redirect_over_load_use");

        // CSR drain over two cycles.
        do_reset();
        de_valid_i = 1; de_serial_i = 1; mem_valid_i = 1; wb_valid_i = 1;
        step("drain_enter");
        mem_valid_i = 0;
        step("drain_wait");
        wb_valid_i = 0;
        step("drain_release");
        idle(); step("drain_done");

        // Memory busy while draining.
        do_reset();
        de_valid_i = 1; de_serial_i = 1; ex_valid_i = 1;
        step("busy_drain_enter");
        dmem_busy_i = 1;
        step("busy_drain_1"); step("busy_drain_2"); step("busy_drain_3");
        dmem_busy_i = 0;
        step("busy_drain_after");

        // Redirect while draining: serial instruction is discarded.
        ex_redirect_i = 1;
        step("drain_redirect");
        idle(); step("post_redirect");

        // Reset in the middle of a drain leaves no residual stall.
        de_valid_i = 1; de_serial_i = 1; wb_valid_i = 1;
        step("drain_again");
        do_reset();
        step("post_reset_idle");

        // Counter saturation and asynchronous clear.
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        dmem_busy_i = 1;
        step("sat_1"); step("sat_2"); step("sat_3");
        dmem_busy_i = 0;
        step("sat_hold");
        rst_ni = 1'b0;
        #1;
        check_now("async_reset_clear");
        @(posedge clk_i); m_drain = 1'b0; m_cnt = '0; #1;
        rst_ni = 1'b1;

        // Randomized cycles.
        for (int n = 0; n < 400; n++) begin
            rst_ni        = ($urandom_range(0, 39) != 0);
            de_valid_i    = ($urandom_range(0, 3) != 0);
            de_rs1_used_i = $urandom_range(0, 1);
            de_rs2_used_i = $urandom_range(0, 1);
            de_rs1_i      = 5'($urandom_range(0, 7));
            de_rs2_i      = 5'($urandom_range(0, 7));
            de_serial_i   = ($urandom_range(0, 4) == 0);
            ex_valid_i    = $urandom_range(0, 1);
            mem_valid_i   = $urandom_range(0, 1);
            wb_valid_i    = $urandom_range(0, 1);
            ex_mem_read_i = $urandom_range(0, 1);
            ex_rf_wr_en_i = ($urandom_range(0, 3) != 0);
            ex_rd_i       = 5'($urandom_range(0, 7));
            ex_redirect_i = ($urandom_range(0, 7) == 0);
            dmem_busy_i   = ($urandom_range(0, 7) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have clk_i, input, 1: the single clock; all state updates on the rising edge.
REQ-002 SHALL have rst_ni, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have de_valid_i, input, 1: decode register holds a valid instruction.
REQ-004 SHALL have de_rs1_used_i / de_rs2_used_i, input, 1 each: decode instruction reads rs1 / rs2.
REQ-005 SHALL have de_rs1_i / de_rs2_i, input, 5 each: decode source register addresses.
REQ-006 SHALL have de_serial_i, input, 1: decode instruction is a CSR write or MRET.
REQ-007 SHALL have ex_valid_i, mem_valid_i, wb_valid_i, input, 1 each: validity of the execute, memory and writeback registers.
REQ-008 SHALL have ex_mem_read_i (1), ex_rf_wr_en_i (1) and ex_rd_i (5), inputs: execute-stage load flag, register-file write enable and destination register.
REQ-009 SHALL have ex_redirect_i, input, 1: execute resolved a taken branch, jump or MRET.
REQ-010 SHALL have dmem_busy_i, input, 1: data memory has not completed the current access.
REQ-011 SHALL have if_ctrl_o, de_ctrl_o, ex_ctrl_o, mem_ctrl_o, wb_ctrl_o, outputs of type stage_ctrl_t {stall, squash}: control for the register written by each stage.
REQ-012 SHALL have stall_cnt_o, output, 32: saturating count of cycles with if_ctrl_o.stall high.

Function
REQ-013 Definition: squash on stage X makes X's output register load valid=0; stall makes it hold.
REQ-014 Priority, highest first: dmem_busy, redirect, DRAIN, load-use, run.
REQ-015 dmem_busy_i=1: stall IF, DE, EX, MEM; squash WB. Every other condition is ignored that cycle.
REQ-016 ex_redirect_i=1, not busy: squash DE and EX, no stalls. FSM goes to RUN from any state.
REQ-017 Load-use: ex_valid_i & ex_mem_read_i & ex_rf_wr_en_i & ex_rd_i!=0 & de_valid_i, plus a used rs matching ex_rd_i. Response: stall IF and DE, squash EX, for one cycle per occurrence.
REQ-018 FSM states: RUN, DRAIN.
REQ-019 RUN->DRAIN when de_valid_i & de_serial_i & (ex|mem|wb valid) and no busy or redirect. That same cycle: stall IF and DE, squash EX.
REQ-020 In DRAIN, while any of ex/mem/wb is valid: stall IF and DE, squash EX.
REQ-021 In DRAIN, when all three are invalid: drive no stalls and no squashes, so the serial instruction advances; next state RUN.
REQ-022 In RUN with a serial instruction and an empty pipeline, no stall occurs and the FSM stays in RUN.
REQ-023 Outputs are combinational from the FSM state and the inputs. Latency is zero cycles.
REQ-024 stall_cnt_o increments by 1 each cycle if_ctrl_o.stall=1 and holds at 32'hFFFF_FFFF.

Reset
REQ-025 While rst_ni=0: state=RUN; stall_cnt_o=0; all stall=0; squash=1 on DE, EX, MEM and WB; if_ctrl_o=0.
REQ-026 Reset asserted mid-DRAIN SHALL abandon the drain immediately, with no residual stall after release.

Structure
REQ-027 The pipe_ctrl_state_e enum (RUN, DRAIN) SHALL live in the shared defs package. stage_ctrl_t stays in the shared pipe-register package.
REQ-028 The load-use comparator SHALL be a combinational sub-module named hazard_detect.
REQ-029 No other sub-modules. Estimated size is 150-250 lines.

Verification
REQ-030 Load-use: EX load to x5, DE uses rs1=x5 -> one cycle of IF/DE stall plus EX squash; stall_cnt_o goes 0->1. With ex_rd_i=x0, no stall.
REQ-031 Redirect concurrent with load-use -> only the DE and EX squash; no stall; stall_cnt_o unchanged.
REQ-032 CSR in DE with mem_valid_i and wb_valid_i draining over 2 cycles -> DRAIN for 2 stall cycles, then release with no stall; state RUN; stall_cnt_o=2.
REQ-033 dmem_busy_i high for 3 cycles during DRAIN -> IF/DE/EX/MEM stalled and WB squashed each cycle; FSM stays in DRAIN; stall_cnt_o +3.
REQ-034 Redirect while in DRAIN -> DE and EX squashed, next state RUN; the serial instruction never issues.
REQ-035 Force stall_cnt_o to 32'hFFFF_FFFE, stall 3 cycles -> value saturates at 32'hFFFF_FFFF. Then assert rst_ni=0 -> 0 asynchronously.
